// File: rtl/matched_filter_pkg.sv
// Shared types, default taps and helpers for the I/Q matched-filter despreader.
package matched_filter_pkg;

  typedef enum logic [0:0] {
    ST_ACQUIRE = 1'b0,
    ST_TRACK   = 1'b1
  } trk_state_e;

  localparam int DEF_TAPS = 20;

  // Shaped Barker set, element [0] is tap 0 (the tap that feeds the output directly).
  localparam int DEF_COEF [DEF_TAPS] = '{
    -87, -130, -120, -141, -157, -57, 99, 155, 129, 139,
    121, -25, -140, -8, 218, 204, -30, -138, -5, 128
  };

  function automatic int mf_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int def_coef(input int k);
    return (k >= 0 && k < DEF_TAPS) ? DEF_COEF[k] : 0;
  endfunction

endpackage

// File: rtl/matched_filter_despreader_param_symbol_timing_tracker.sv
// Correlation-energy peak tracking per symbol window, lock FSM and symbol pick-off.
module symbol_timing_tracker
  import matched_filter_pkg::*;
#(
  parameter int ACC_W    = 37,
  parameter int SYM_LEN  = 20,
  parameter int LOSS_CNT = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_vld,
  input  logic signed [ACC_W-1:0]         in_i,
  input  logic signed [ACC_W-1:0]         in_q,
  input  logic        [ACC_W:0]           energy_thresh,
  output logic signed [ACC_W-1:0]         symbol_i,
  output logic signed [ACC_W-1:0]         symbol_q,
  output logic                            symbol_valid,
  output logic                            lock,
  output logic        [mf_clog2(SYM_LEN)-1:0] peak_phase
);

  localparam int PW = mf_clog2(SYM_LEN);
  localparam int MW = mf_clog2(LOSS_CNT + 1);
  localparam logic [PW-1:0] LAST_PH = PW'(SYM_LEN - 1);

  // The magnitude of the most-negative value is exact as an unsigned ACC_W word.
  function automatic logic [ACC_W-1:0] mag(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  trk_state_e              state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [ACC_W:0]          max_q, max_d;
  logic [PW-1:0]           argmax_q, argmax_d;
  logic [PW-1:0]           peak_q, peak_d;
  logic [PW-1:0]           cand_q, cand_d;
  logic [MW-1:0]           miss_q, miss_d;
  logic signed [ACC_W-1:0] sym_i_q, sym_i_d;
  logic signed [ACC_W-1:0] sym_q_q, sym_q_d;
  logic                    vld_p2_q, vld_p2_d;

  logic [ACC_W:0]          energy;
  logic [ACC_W:0]          cur_max;
  logic [PW-1:0]           cur_arg;
  logic                    win_start;
  logic                    win_end;

  always_comb begin
    energy    = {1'b0, mag(in_i)} + {1'b0, mag(in_q)};
    win_start = (phase_q == '0);
    win_end   = (phase_q == LAST_PH);
    // Strict compare keeps the earliest phase on a tie; the window start discards the old max.
    if (win_start || (energy > max_q)) begin
      cur_max = energy;
      cur_arg = phase_q;
    end else begin
      cur_max = max_q;
      cur_arg = argmax_q;
    end

    state_d  = state_q;
    phase_d  = phase_q;
    max_d    = max_q;
    argmax_d = argmax_q;
    peak_d   = peak_q;
    cand_d   = cand_q;
    miss_d   = miss_q;
    sym_i_d  = sym_i_q;
    sym_q_d  = sym_q_q;
    vld_p2_d = 1'b0;

    if (in_vld) begin
      max_d    = cur_max;
      argmax_d = cur_arg;
      phase_d  = win_end ? '0 : phase_q + PW'(1);

      if (state_q == ST_TRACK && phase_q == peak_q) begin
        vld_p2_d = 1'b1;
        sym_i_d  = in_i;
        sym_q_d  = in_q;
      end

      if (win_end) begin
        cand_d = cur_arg;
        unique case (state_q)
          ST_ACQUIRE: begin
            if (cur_max >= energy_thresh) begin
              state_d = ST_TRACK;
              peak_d  = cur_arg;
              miss_d  = '0;
            end
          end
          ST_TRACK: begin
            // Re-lock only when the same new phase wins two windows running.
            if (cur_arg != peak_q && cur_arg == cand_q) peak_d = cur_arg;
            if (cur_max < energy_thresh) begin
              if (miss_q == MW'(LOSS_CNT - 1)) begin
                state_d = ST_ACQUIRE;
                miss_d  = '0;
                phase_d = '0;
              end else begin
                miss_d = miss_q + MW'(1);
              end
            end else begin
              miss_d = '0;
            end
          end
          default: state_d = ST_ACQUIRE;
        endcase
      end
    end
  end

  // Stage p2: window decision and symbol registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ACQUIRE;
      phase_q  <= '0;
      max_q    <= '0;
      argmax_q <= '0;
      peak_q   <= '0;
      cand_q   <= '0;
      miss_q   <= '0;
      sym_i_q  <= '0;
      sym_q_q  <= '0;
      vld_p2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      max_q    <= max_d;
      argmax_q <= argmax_d;
      peak_q   <= peak_d;
      cand_q   <= cand_d;
      miss_q   <= miss_d;
      sym_i_q  <= sym_i_d;
      sym_q_q  <= sym_q_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  assign symbol_i     = sym_i_q;
  assign symbol_q     = sym_q_q;
  assign symbol_valid = vld_p2_q;
  assign lock         = (state_q == ST_TRACK);
  assign peak_phase   = peak_q;

endmodule

// File: rtl/matched_filter_despreader_param.sv
// Transposed-form I/Q matched filter with programmable taps feeding the symbol-timing tracker.
module matched_filter_despreader_param
  import matched_filter_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 20,
  parameter int ACC_W    = 37,
  parameter int SYM_LEN  = 20,
  parameter int LOSS_CNT = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic signed [IN_W-1:0]           sample_i,
  input  logic signed [IN_W-1:0]           sample_q,
  input  logic                             input_sample_valid,
  input  logic                             coef_wr_en,
  input  logic        [mf_clog2(TAPS)-1:0] coef_wr_addr,
  input  logic signed [COEF_W-1:0]         coef_wr_data,
  input  logic        [ACC_W:0]            energy_thresh,
  output logic signed [ACC_W-1:0]          despread_sample_i,
  output logic signed [ACC_W-1:0]          despread_sample_q,
  output logic                             despread_sample_valid,
  output logic signed [ACC_W-1:0]          symbol_i,
  output logic signed [ACC_W-1:0]          symbol_q,
  output logic                             symbol_valid,
  output logic                             lock,
  output logic        [mf_clog2(SYM_LEN)-1:0] peak_phase
);

  localparam int AW  = mf_clog2(TAPS);
  localparam int PRW = IN_W + COEF_W;

  // Full-precision product, sign-extended into the accumulator width.
  function automatic logic signed [ACC_W-1:0] tap_prod(
    input logic signed [IN_W-1:0]   x,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [PRW-1:0] p;
    p = PRW'(x) * PRW'(c);
    return ACC_W'(p);
  endfunction

  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic signed [ACC_W-1:0]  acci_q [TAPS];
  logic signed [ACC_W-1:0]  acci_d [TAPS];
  logic signed [ACC_W-1:0]  accq_q [TAPS];
  logic signed [ACC_W-1:0]  accq_d [TAPS];
  logic                     vld_p1_q, vld_p1_d;
  logic                     wr_ok;

  // Writes land after this edge, so a coincident sample still sees the old tap.
  always_comb begin
    wr_ok = coef_wr_en && (int'(coef_wr_addr) < TAPS);
    for (int k = 0; k < TAPS; k++) begin
      coef_d[k] = coef_q[k];
      if (wr_ok && coef_wr_addr == AW'(k)) coef_d[k] = coef_wr_data;
    end
  end

  always_comb begin
    vld_p1_d = input_sample_valid;
    for (int k = 0; k < TAPS; k++) begin
      acci_d[k] = acci_q[k];
      accq_d[k] = accq_q[k];
    end
    if (input_sample_valid) begin
      for (int k = 0; k < TAPS - 1; k++) begin
        acci_d[k] = acci_q[k+1] + tap_prod(sample_i, coef_q[k]);
        accq_d[k] = accq_q[k+1] + tap_prod(sample_q, coef_q[k]);
      end
      acci_d[TAPS-1] = tap_prod(sample_i, coef_q[TAPS-1]);
      accq_d[TAPS-1] = tap_prod(sample_q, coef_q[TAPS-1]);
    end
  end

  // Stage p1: coefficient bank and accumulator chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= COEF_W'(def_coef(k));
        acci_q[k] <= '0;
        accq_q[k] <= '0;
      end
      vld_p1_q <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= coef_d[k];
        acci_q[k] <= acci_d[k];
        accq_q[k] <= accq_d[k];
      end
      vld_p1_q <= vld_p1_d;
    end
  end

  assign despread_sample_i     = acci_q[0];
  assign despread_sample_q     = accq_q[0];
  assign despread_sample_valid = vld_p1_q;

  symbol_timing_tracker #(
    .ACC_W    (ACC_W),
    .SYM_LEN  (SYM_LEN),
    .LOSS_CNT (LOSS_CNT)
  ) u_tracker (
    .clk           (clk),
    .reset         (reset),
    .in_vld        (vld_p1_q),
    .in_i          (acci_q[0]),
    .in_q          (accq_q[0]),
    .energy_thresh (energy_thresh),
    .symbol_i      (symbol_i),
    .symbol_q      (symbol_q),
    .symbol_valid  (symbol_valid),
    .lock          (lock),
    .peak_phase    (peak_phase)
  );

endmodule

// File: tb/tb_matched_filter_despreader_param.sv
// Bench for matched_filter_despreader_param: sample-indexed reference model plus directed literal checks.
module tb_matched_filter_despreader_param;

  localparam int IN_W = 16, COEF_W = 16, TAPS = 20, ACC_W = 37, SYM_LEN = 20, LOSS_CNT = 4;
  localparam int AW = 5, PW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [IN_W-1:0]   sample_i = '0, sample_q = '0;
  logic                     input_sample_valid = 1'b0;
  logic                     coef_wr_en = 1'b0;
  logic        [AW-1:0]     coef_wr_addr = '0;
  logic signed [COEF_W-1:0] coef_wr_data = '0;
  logic        [ACC_W:0]    energy_thresh = '1;
  logic signed [ACC_W-1:0]  despread_sample_i, despread_sample_q, symbol_i, symbol_q;
  logic                     despread_sample_valid, symbol_valid, lock;
  logic        [PW-1:0]     peak_phase;

  always #5 clk = ~clk;

  matched_filter_despreader_param #(
    .IN_W(IN_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W), .SYM_LEN(SYM_LEN), .LOSS_CNT(LOSS_CNT)
  ) dut (
    .clk(clk), .reset(rst),
    .sample_i(sample_i), .sample_q(sample_q), .input_sample_valid(input_sample_valid),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .energy_thresh(energy_thresh),
    .despread_sample_i(despread_sample_i), .despread_sample_q(despread_sample_q),
    .despread_sample_valid(despread_sample_valid),
    .symbol_i(symbol_i), .symbol_q(symbol_q), .symbol_valid(symbol_valid),
    .lock(lock), .peak_phase(peak_phase)
  );

  int DEFC [TAPS] = '{-87, -130, -120, -141, -157, -57, 99, 155, 129, 139,
                      121, -25, -140, -8, 218, 204, -30, -138, -5, 128};

  int n_vec = 0;
  int n_err = 0;
  int sym_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (indexed by accepted-sample number) ----------------
  longint mxi[$], mxq[$];
  int     chist[$];
  int     mcoef [TAPS];
  longint m_di, m_dq, m_si, m_sq;
  bit     m_dsv, m_symv, m_lock;
  int     m_peak, m_cand, m_miss, n_out;
  longint wen [SYM_LEN];

  function automatic longint mabs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    mxi.delete(); mxq.delete(); chist.delete();
    for (int k = 0; k < TAPS; k++) mcoef[k] = DEFC[k];
    m_di = 0; m_dq = 0; m_si = 0; m_sq = 0;
    m_dsv = 0; m_symv = 0; m_lock = 0;
    m_peak = 0; m_cand = 0; m_miss = 0; n_out = 0;
    for (int p = 0; p < SYM_LEN; p++) wen[p] = 0;
  endtask

  // One filter output enters the timing tracker.
  task automatic trk_step(input longint di, input longint dq, input longint thr);
    int ph, best;
    ph = n_out % SYM_LEN;
    wen[ph] = mabs(di) + mabs(dq);
    if (m_lock && ph == m_peak) begin
      m_symv = 1; m_si = di; m_sq = dq;
    end
    n_out++;
    if (ph == SYM_LEN - 1) begin
      best = 0;
      for (int p = 1; p < SYM_LEN; p++) if (wen[p] > wen[best]) best = p;
      if (!m_lock) begin
        if (wen[best] >= thr) begin m_lock = 1; m_peak = best; m_miss = 0; end
      end else begin
        if (best != m_peak && best == m_cand) m_peak = best;
        if (wen[best] < thr) begin
          m_miss++;
          if (m_miss == LOSS_CNT) begin m_lock = 0; m_miss = 0; n_out = 0; end
        end else m_miss = 0;
      end
      m_cand = best;
    end
  endtask

  // y[n] = sum_k x[n-k] * (tap k as it was when x[n-k] arrived)
  task automatic filter_push(input longint xi, input longint xq);
    int n;
    longint yi, yq;
    mxi.push_back(xi); mxq.push_back(xq);
    for (int k = 0; k < TAPS; k++) chist.push_back(mcoef[k]);
    n = mxi.size() - 1;
    yi = 0; yq = 0;
    for (int k = 0; k < TAPS; k++) begin
      if (n - k >= 0) begin
        yi += mxi[n-k] * chist[(n-k)*TAPS + k];
        yq += mxq[n-k] * chist[(n-k)*TAPS + k];
      end
    end
    m_di = (yi <<< (64 - ACC_W)) >>> (64 - ACC_W);
    m_dq = (yq <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endtask

  always @(posedge clk) begin : cmp
    longint thr;
    thr = longint'(energy_thresh);
    if (rst) model_reset();
    else begin
      m_symv = 0;
      if (m_dsv) trk_step(m_di, m_dq, thr);
      m_dsv = input_sample_valid;
      if (input_sample_valid) filter_push(longint'(sample_i), longint'(sample_q));
      if (coef_wr_en && int'(coef_wr_addr) < TAPS) mcoef[coef_wr_addr] = int'(coef_wr_data);
    end
    #1;
    chk("dsv", despread_sample_valid, m_dsv);
    chk("di", despread_sample_i, m_di);
    chk("dq", despread_sample_q, m_dq);
    chk("symv", symbol_valid, m_symv);
    chk("si", symbol_i, m_si);
    chk("sq", symbol_q, m_sq);
    chk("lock", lock, m_lock);
    chk("peak", peak_phase, m_peak);
    if (symbol_valid) sym_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input longint xi, input longint xq,
                       input bit we = 0, input int wa = 0, input int wd = 0);
    @(negedge clk);
    input_sample_valid = v;
    sample_i     = IN_W'(xi);
    sample_q     = IN_W'(xq);
    coef_wr_en   = we;
    coef_wr_addr = AW'(wa);
    coef_wr_data = COEF_W'(wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    input_sample_valid = 1'b0;
    coef_wr_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // 20 samples, one impulse of amplitude amp at position pos (pos < 0: all zero).
  task automatic feed_win(input int pos, input longint amp);
    for (int j = 0; j < SYM_LEN; j++) drive(1, (j == pos) ? amp : 0, (j == pos) ? amp : 0);
    idle(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_dsv", despread_sample_valid, 0);
    chk("rst_di", despread_sample_i, 0);
    chk("rst_symv", symbol_valid, 0);
    chk("rst_lock", lock, 0);
    chk("rst_peak", peak_phase, 0);
    rst = 1'b0;
    energy_thresh = '1;

    // impulse response with default taps
    drive(1, 1, -1);
    for (int k = 0; k < TAPS; k++) begin
      drive(k < TAPS - 1, 0, 0);
      chk("imp_i", despread_sample_i, DEFC[k]);
      chk("imp_q", despread_sample_q, -DEFC[k]);
    end

    // tap write coinciding with a sample, then the next sample
    drive(1, 3, 3, 1, 0, 1000);
    drive(1, 1, 1);
    chk("wr_old_tap", despread_sample_i, -261);
    drive(0, 0, 0, 1, 25, 777);
    chk("wr_new_tap", despread_sample_i, 610);
    for (int j = 0; j < TAPS; j++) drive(1, 0, 0);
    drive(1, 1, 1);
    drive(1, 0, 0);
    chk("wr_c0", despread_sample_i, 1000);
    drive(0, 0, 0);
    chk("wr_c1", despread_sample_i, -130);

    // lock acquisition on an impulse train peaking at phase 7 (reset lands mid-window)
    do_reset();
    energy_thresh = 38'd42000;
    feed_win(13, 100);
    chk("acq_w0_lock", lock, 0);
    feed_win(13, 100);
    chk("acq_w1_lock", lock, 1);
    chk("acq_w1_peak", peak_phase, 7);
    sym_cnt = 0;
    feed_win(13, 100);
    chk("sym_per_win", sym_cnt, 1);
    chk("sym_val", symbol_i, 21800);

    // peak moves 7 -> 9: two-window hysteresis
    feed_win(15, 100);
    chk("shift_w3_peak", peak_phase, 7);
    feed_win(15, 100);
    chk("shift_w4_peak", peak_phase, 7);
    feed_win(15, 100);
    chk("shift_w5_peak", peak_phase, 9);

    // loss of lock on zero input
    for (int w = 0; w < 4; w++) feed_win(-1, 0);
    chk("loss_w9_lock", lock, 1);
    feed_win(-1, 0);
    chk("loss_w10_lock", lock, 0);
    feed_win(13, 100);
    feed_win(13, 100);
    chk("relock_peak", peak_phase, 7);
    chk("relock_lock", lock, 1);

    // randomized segments: gaps, tap writes, thresholds, one mid-stream reset
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      int mode, gap, pos, amp, cnt;
      mode = $urandom_range(0, 1);
      gap  = seg % 3;
      pos  = $urandom_range(0, SYM_LEN - 1);
      amp  = $urandom_range(50, 3000);
      cnt  = 0;
      if (mode == 0) energy_thresh = 38'($urandom_range(0, 32'h0400_0000));
      else           energy_thresh = 38'($urandom_range(0, 500 * amp));
      for (int c = 0; c < 240; c++) begin
        bit v, we;
        longint xi, xq;
        int wa, wd;
        case (gap)
          0:       v = 1'b1;
          1:       v = (c % 3 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        if (mode == 0) begin
          xi = longint'(int'($urandom_range(0, 65535)) - 32768);
          xq = longint'(int'($urandom_range(0, 65535)) - 32768);
        end else begin
          xi = (cnt % SYM_LEN == pos) ? amp : int'($urandom_range(0, 2)) - 1;
          xq = (cnt % SYM_LEN == pos) ? -amp : int'($urandom_range(0, 2)) - 1;
        end
        if (v) cnt++;
        we = (mode == 0) && ($urandom_range(0, 15) == 0);
        wa = $urandom_range(0, 31);
        wd = int'($urandom_range(0, 65535)) - 32768;
        drive(v, xi, xq, we, wa, wd);
        if (seg == 4 && c == 117) do_reset();
      end
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
